mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have no module parameters; address width SHALL be `AddrLen (32) and data word width SHALL be 32, both taken from config.vh.
REQ-002 clk  in  1  single clock; all state updates SHALL occur on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset (`ResetEnable); sampled on rising edge of clk.
REQ-004 if_req  in  1  instruction fetch request; held high until if_done.
REQ-005 if_addr  in  32  fetch address (pc).
REQ-006 if_flush  in  1  jump taken; abort any in-flight fetch.
REQ-007 if_done  out  1  one-cycle pulse; if_inst is valid.
REQ-008 if_inst  out  32  fetched instruction, little-endian.
REQ-009 mem_req  in  1  load/store request; held high until mem_done.
REQ-010 mem_wr_en  in  1  1=store, 0=load.
REQ-011 mem_addr  in  32  load/store byte address.
REQ-012 mem_len  in  2  0=byte, 1=half, 3=word (2 is illegal and is treated as 3).
REQ-013 mem_wdata  in  32  store data; bytes 0..N-1 are used.
REQ-014 mem_done  out  1  one-cycle pulse; load/store is complete.
REQ-015 mem_rdata  out  32  load data, zero-extended above N bytes.
REQ-016 ram_din  in  8  RAM read byte; valid the cycle after its address.
REQ-017 ram_dout  out  8  RAM write byte.
REQ-018 ram_a  out  32  RAM byte address.
REQ-019 ram_wr  out  1  1=write this cycle.
REQ-020 stallreq_if  out  1  combinational: if_req & ~if_done.
REQ-021 stallreq_mem  out  1  combinational: mem_req & ~mem_done.

Function
REQ-022 The FSM states SHALL be IDLE, IF_RD, MEM_RD and MEM_WR.
REQ-023 In IDLE, a pending mem_req SHALL win over if_req (the older instruction has priority); the winner's addr, len and wdata SHALL be latched and cnt cleared to 0.
REQ-024 A port's req SHALL be ignored in the cycle its done pulse is high.
REQ-025 Read (N bytes, IF N=4): for cnt=0..N-1, ram_a=base+cnt; for cnt=1..N, ram_din SHALL be stored in byte cnt-1; at cnt=N the FSM SHALL go to IDLE and done SHALL be registered for the next cycle.
REQ-026 Read latency SHALL be: request seen in IDLE at cycle 0, FSM in RD cycles 1..N+1, done at cycle N+2 (6 for a word).
REQ-027 Write: for cnt=0..N-1, ram_wr=1, ram_a=base+cnt, ram_dout=wdata byte cnt; after cnt=N-1 the FSM SHALL go to IDLE with done at cycle N+1.
REQ-028 ram_wr SHALL be 0 in every state except MEM_WR.
REQ-029 ram_a SHALL be 0 in IDLE.
REQ-030 base+cnt SHALL wrap modulo 2^32.
REQ-031 if_flush high in IF_RD SHALL force IDLE next cycle with no if_done, and if_inst SHALL hold its previous value.
REQ-032 if_flush SHALL NOT affect MEM_RD or MEM_WR.
REQ-033 if_flush high in IDLE SHALL suppress IF acceptance that cycle.
REQ-034 if_inst and mem_rdata SHALL hold their values until the next completion.

Reset
REQ-035 rst SHALL force IDLE and cnt=0.
REQ-036 rst SHALL force if_done, mem_done, ram_wr, ram_a and ram_dout to 0.
REQ-037 rst SHALL force if_inst and mem_rdata to 0.
REQ-038 rst asserted mid-transfer SHALL abandon the transfer with no done pulse; a write may be partially performed.

Structure
REQ-039 State encodings and the mem_len codes SHALL be `define constants in config.vh.
REQ-040 The block SHALL be a single module with no sub-modules; the byte assembler is inline.

Verification
REQ-041 IF only: if_addr=0x100, RAM[0x100..0x103]=13,05,10,00 -> ram_a 0x100..0x103 in cycles 1..4; if_done at cycle 6; if_inst=0x00100513.
REQ-042 Simultaneous if_req and mem_req (load word, addr 0x200) -> MEM_RD served first; mem_done at 6; IF accepted at 7; if_done at 13.
REQ-043 Store half: addr 0x3FF, wdata=0xAABBCCDD -> ram_wr in cycles 1..2 with (0x3FF,DD), (0x400,CC); mem_done at 3.
REQ-044 if_flush in IF_RD cnt=2 -> IDLE next cycle; no if_done; new if_addr accepted the following cycle.
REQ-045 Byte load at 0xFFFFFFFF, then word load at 0xFFFFFFFE -> mem_rdata zero-extended for the byte load; ram_a wraps to 0x00000000 on the word load.
REQ-046 rst in MEM_WR cnt=1 -> IDLE next cycle; ram_wr=0; no mem_done.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Configuration constants for the memory arbiter: bus widths, FSM state codes
// and load/store length codes, plus the length-code decoder.
`ifndef MEM_ARBITER_CONFIG_VH
`define MEM_ARBITER_CONFIG_VH
`define AddrLen     32
`define DataLen     32
`define ResetEnable 1'b1
`define StIdle      2'd0
`define StIfRd      2'd1
`define StMemRd     2'd2
`define StMemWr     2'd3
`define LenByte     2'd0
`define LenHalf     2'd1
`define LenWord     2'd3
`endif

package mem_arbiter_pkg;

   localparam int ADDR_W = `AddrLen;
   localparam int DATA_W = `DataLen;

   localparam logic [1:0] ST_IDLE   = `StIdle;
   localparam logic [1:0] ST_IF_RD  = `StIfRd;
   localparam logic [1:0] ST_MEM_RD = `StMemRd;
   localparam logic [1:0] ST_MEM_WR = `StMemWr;

   // The illegal code 2 falls into the default and moves a full word.
   function automatic logic [2:0] len_bytes(input logic [1:0] len);
      logic [2:0] n;
      case (len)
         `LenByte: n = 3'd1;
         `LenHalf: n = 3'd2;
         default:  n = 3'd4;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Shares one byte-wide RAM port between instruction fetch and load/store,
// moving one byte per cycle; load/store wins arbitration over fetch.
module mem_arbiter
   import mem_arbiter_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              if_flush,
   output logic              if_done,
   output logic [DATA_W-1:0] if_inst,
   input  logic              mem_req,
   input  logic              mem_wr_en,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [1:0]        mem_len,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic              mem_done,
   output logic [DATA_W-1:0] mem_rdata,
   input  logic [7:0]        ram_din,
   output logic [7:0]        ram_dout,
   output logic [ADDR_W-1:0] ram_a,
   output logic              ram_wr,
   output logic              stallreq_if,
   output logic              stallreq_mem
);

   logic [1:0]        state_q,     state_d;
   logic [2:0]        cnt_q,       cnt_d;
   logic [2:0]        nbytes_q,    nbytes_d;
   logic [ADDR_W-1:0] base_q,      base_d;
   logic [DATA_W-1:0] wdata_q,     wdata_d;
   logic [DATA_W-1:0] asm_q,       asm_d;
   logic              if_done_q,   if_done_d;
   logic              mem_done_q,  mem_done_d;
   logic [DATA_W-1:0] if_inst_q,   if_inst_d;
   logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
   logic [ADDR_W-1:0] ram_a_q,     ram_a_d;
   logic [7:0]        ram_dout_q,  ram_dout_d;
   logic              ram_wr_q,    ram_wr_d;

   // Arbitration, byte counting and read-data assembly.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      nbytes_d    = nbytes_q;
      base_d      = base_q;
      wdata_d     = wdata_q;
      asm_d       = asm_q;
      if_done_d   = 1'b0;
      mem_done_d  = 1'b0;
      if_inst_d   = if_inst_q;
      mem_rdata_d = mem_rdata_q;
      case (state_q)
         ST_IDLE: begin
            // No acceptance while a done pulse is out: the requester has not
            // yet had a chance to drop the request it just completed.
            if (if_done_q || mem_done_q) begin
               state_d = ST_IDLE;
            end else if (mem_req) begin
               state_d  = mem_wr_en ? ST_MEM_WR : ST_MEM_RD;
               base_d   = mem_addr;
               nbytes_d = len_bytes(mem_len);
               wdata_d  = mem_wdata;
               cnt_d    = 3'd0;
               asm_d    = {DATA_W{1'b0}};
            end else if (if_req && !if_flush) begin
               state_d  = ST_IF_RD;
               base_d   = if_addr;
               nbytes_d = 3'd4;
               cnt_d    = 3'd0;
               asm_d    = {DATA_W{1'b0}};
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_IF_RD, ST_MEM_RD: begin
            // ram_din lags its address by one cycle, so count c holds byte c-1.
            case (cnt_q)
               3'd1:    asm_d[7:0]   = ram_din;
               3'd2:    asm_d[15:8]  = ram_din;
               3'd3:    asm_d[23:16] = ram_din;
               3'd4:    asm_d[31:24] = ram_din;
               default: asm_d        = asm_q;
            endcase
            if (state_q == ST_IF_RD && if_flush) begin
               state_d = ST_IDLE;
               cnt_d   = 3'd0;
            end else if (cnt_q == nbytes_q) begin
               state_d = ST_IDLE;
               cnt_d   = 3'd0;
               if (state_q == ST_IF_RD) begin
                  if_done_d = 1'b1;
                  if_inst_d = asm_d;
               end else begin
                  mem_done_d  = 1'b1;
                  mem_rdata_d = asm_d;
               end
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         ST_MEM_WR: begin
            if (cnt_q == nbytes_q - 3'd1) begin
               state_d    = ST_IDLE;
               cnt_d      = 3'd0;
               mem_done_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 3'd0;
         end
      endcase
   end

   // RAM port values for the coming cycle, derived from the next state.
   always_comb begin
      ram_a_d    = {ADDR_W{1'b0}};
      ram_wr_d   = 1'b0;
      ram_dout_d = 8'd0;
      if (state_d != ST_IDLE) begin
         ram_a_d = base_d + {{(ADDR_W-3){1'b0}}, cnt_d};
         if (state_d == ST_MEM_WR) begin
            ram_wr_d   = 1'b1;
            ram_dout_d = 8'(wdata_d >> {cnt_d[1:0], 3'b000});
         end else begin
            ram_wr_d   = 1'b0;
            ram_dout_d = 8'd0;
         end
      end else begin
         ram_a_d = {ADDR_W{1'b0}};
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst == `ResetEnable) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 3'd0;
         nbytes_q    <= 3'd0;
         base_q      <= {ADDR_W{1'b0}};
         wdata_q     <= {DATA_W{1'b0}};
         asm_q       <= {DATA_W{1'b0}};
         if_done_q   <= 1'b0;
         mem_done_q  <= 1'b0;
         if_inst_q   <= {DATA_W{1'b0}};
         mem_rdata_q <= {DATA_W{1'b0}};
         ram_a_q     <= {ADDR_W{1'b0}};
         ram_dout_q  <= 8'd0;
         ram_wr_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         nbytes_q    <= nbytes_d;
         base_q      <= base_d;
         wdata_q     <= wdata_d;
         asm_q       <= asm_d;
         if_done_q   <= if_done_d;
         mem_done_q  <= mem_done_d;
         if_inst_q   <= if_inst_d;
         mem_rdata_q <= mem_rdata_d;
         ram_a_q     <= ram_a_d;
         ram_dout_q  <= ram_dout_d;
         ram_wr_q    <= ram_wr_d;
      end
   end

   assign if_done      = if_done_q;
   assign if_inst      = if_inst_q;
   assign mem_done     = mem_done_q;
   assign mem_rdata    = mem_rdata_q;
   assign ram_a        = ram_a_q;
   assign ram_dout     = ram_dout_q;
   assign ram_wr       = ram_wr_q;
   assign stallreq_if  = if_req & ~if_done_q;
   assign stallreq_mem = mem_req & ~mem_done_q;

endmodule
